// File: rtl/pn_ctrl_pkg.sv
// pn_ctrl_pkg -- shared definitions for the PN code controller.
//   state_t     : controller FSM states (IDLE, LOAD, PRIME, RUN)
//   CODE_LEN    : chips per code period (1023)
//   PRN_MIN     : lowest accepted PRN select code
//   LAST_CHIP   : chip index at which the period wraps
//   prn_ok()    : range check of a requested PRN against PRN_MIN..prn_max
package pn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int CODE_LEN = 1023;
  localparam int PRN_MIN  = 1;
  localparam logic [9:0] LAST_CHIP = 10'(CODE_LEN - 1);

  function automatic logic prn_ok(input logic [3:0] prn, input int prn_max);
    return (int'(prn) >= PRN_MIN) && (int'(prn) <= prn_max);
  endfunction

endpackage

// File: rtl/chip_strobe_div.sv
// chip_strobe_div -- divides clk down to one chip strobe every DIV cycles.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clear  : forces the count back to 0 (has priority over en)
//   en     : count enable
//   strobe : combinational terminal-count pulse; with the count at 0 on
//            the first enabled cycle, strobe is high on the DIV-th one
module chip_strobe_div #(
  parameter int DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic strobe
);

  localparam logic [7:0] TERM = 8'(DIV - 1);

  logic [7:0] cnt;

  assign strobe = en && !clear && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pn_code_ctrl.sv
// pn_code_ctrl -- sequences a PN code generator: accepts a PRN request,
// resets/loads the generator, then issues chip-advance enables and tracks
// the chip index and code-period epochs. PRN changes only at an epoch.
//
// Handshake: a request transfers on any clock edge where req_valid and
// req_ready are both high; req_ready is high exactly while the pending
// register is empty. An out-of-range PRN is consumed but not stored, and
// req_err pulses on the following cycle.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_prn/valid/ready  : PRN request handshake
//   start, stop          : begin / abort generation (stop has priority)
//   gen_rst_n, gen_sel   : generator reset (low in LOAD) and PRN select
//   gen_ce               : one-cycle chip-advance enable
//   chip_idx, epoch      : chip index 0..1022 and period-wrap pulse
//   busy, req_err        : not-IDLE flag, rejected-request pulse
//   epoch_cnt            : epoch counter (built only with PN_EPOCH_CNT_EN)
//   fsm_state            : current FSM state for observation
//
// Build option: define PN_EPOCH_CNT_EN to build the epoch counter;
// otherwise epoch_cnt is tied to 0.
module pn_code_ctrl
  import pn_ctrl_pkg::*;
#(
  parameter int CHIP_DIV = 20,
  parameter int PRN_MAX  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_prn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       start,
  input  logic       stop,
  output logic       gen_rst_n,
  output logic [3:0] gen_sel,
  output logic       gen_ce,
  output logic [9:0] chip_idx,
  output logic       epoch,
  output logic       busy,
  output logic       req_err,
  output logic [7:0] epoch_cnt,
  output state_t     fsm_state
);

  state_t     state;
  logic       pend_valid;
  logic [3:0] pend_prn;
  logic       accept;
  logic       prn_good;
  logic       tick;
  logic       wrap;
  logic       enter_load;
  logic       div_en;
  logic       div_clear;

  assign req_ready = !pend_valid;
  assign accept    = req_valid && req_ready;
  assign prn_good  = prn_ok(req_prn, PRN_MAX);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // The divider only runs in RUN; a stop clears it so no chip strobe can
  // escape in the cycle the controller aborts.
  assign div_en    = (state == RUN) && !stop;
  assign div_clear = (state != RUN) || stop;

  chip_strobe_div #(.DIV(CHIP_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clear  (div_clear),
    .en     (div_en),
    .strobe (tick)
  );

  assign wrap       = tick && (chip_idx == LAST_CHIP);
  assign enter_load = !stop && pend_valid &&
                      (((state == IDLE) && start) || ((state == RUN) && wrap));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_prn   <= 4'd0;
      gen_rst_n  <= 1'b0;
      gen_sel    <= 4'd0;
      gen_ce     <= 1'b0;
      chip_idx   <= 10'd0;
      epoch      <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      gen_ce  <= 1'b0;
      epoch   <= 1'b0;
      req_err <= accept && !prn_good;

      // accept needs an empty pending slot and enter_load a full one,
      // so these two never collide.
      if (accept && prn_good) begin
        pend_valid <= 1'b1;
        pend_prn   <= req_prn;
      end else if (enter_load) begin
        pend_valid <= 1'b0;
      end

      if (stop) begin
        state     <= IDLE;
        gen_rst_n <= 1'b1;
        gen_sel   <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            gen_rst_n <= 1'b1;
            gen_sel   <= 4'd0;
            if (enter_load) begin
              state     <= LOAD;
              gen_rst_n <= 1'b0;
              gen_sel   <= pend_prn;
              chip_idx  <= 10'd0;
            end
          end
          LOAD: begin
            state     <= PRIME;
            gen_rst_n <= 1'b1;
          end
          PRIME: begin
            state <= RUN;
          end
          RUN: begin
            if (tick) begin
              gen_ce <= 1'b1;
              if (wrap) begin
                chip_idx <= 10'd0;
                epoch    <= 1'b1;
                if (enter_load) begin
                  state     <= LOAD;
                  gen_rst_n <= 1'b0;
                  gen_sel   <= pend_prn;
                end
              end else begin
                chip_idx <= chip_idx + 10'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PN_EPOCH_CNT_EN
  logic [7:0] ep_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || (state == LOAD)) begin
      ep_cnt_q <= 8'd0;
    end else if (wrap) begin
      ep_cnt_q <= ep_cnt_q + 8'd1;
    end
  end

  assign epoch_cnt = ep_cnt_q;
`else
  assign epoch_cnt = 8'd0;
`endif

endmodule
